// File: rtl/rs_alu_pkg.sv
// rtl/rs_alu_pkg.sv - shared widths, sentinels, entry types and CDB snoop helper
//
// Purpose: common definitions for the ALU reservation station.
//   Widths: opTypeWidth, dataWidth, immWidth, addrWidth, tagWidth
//   Sentinels: emptyTag (operand value valid), emptyOp (no issue), emptyData
//   Types: operand_t (value + producer tag), rs_entry_t (one station slot)
//   snoop(): resolves an operand against the two result buses
package rs_alu_pkg;

  localparam int opTypeWidth      = 6;
  localparam int dataWidth        = 32;
  localparam int immWidth         = 32;
  localparam int addrWidth        = 32;
  localparam int tagWidth         = 5;
  localparam int RS_DEPTH_DEFAULT = 16;

  localparam logic [tagWidth-1:0]    emptyTag  = '0;
  localparam logic [opTypeWidth-1:0] emptyOp   = '0;
  localparam logic [dataWidth-1:0]   emptyData = '0;

  localparam logic [opTypeWidth-1:0] OP_ADD  = 6'd1;
  localparam logic [opTypeWidth-1:0] OP_SUB  = 6'd2;
  localparam logic [opTypeWidth-1:0] OP_XOR  = 6'd3;
  localparam logic [opTypeWidth-1:0] OP_OR   = 6'd4;
  localparam logic [opTypeWidth-1:0] OP_SLLI = 6'd5;
  localparam logic [opTypeWidth-1:0] OP_BEQ  = 6'd6;

  typedef struct packed {
    logic [dataWidth-1:0] v;
    logic [tagWidth-1:0]  q;
  } operand_t;

  typedef struct packed {
    logic [opTypeWidth-1:0] op;
    logic [dataWidth-1:0]   vj;
    logic [dataWidth-1:0]   vk;
    logic [tagWidth-1:0]    qj;
    logic [tagWidth-1:0]    qk;
    logic [immWidth-1:0]    imm;
    logic [addrWidth-1:0]   pc;
    logic [tagWidth-1:0]    dest;
  } rs_entry_t;

  // A pending operand takes data from whichever bus carries its producer tag;
  // the ALU bus wins if both match. A non-empty q can only match a non-empty
  // bus tag, so an idle bus (emptyTag) never wakes anything.
  function automatic operand_t snoop(
    input operand_t              cur,
    input logic [tagWidth-1:0]   alu_tag,
    input logic [dataWidth-1:0]  alu_data,
    input logic [tagWidth-1:0]   lsb_tag,
    input logic [dataWidth-1:0]  lsb_data
  );
    operand_t res;
    res = cur;
    if (cur.q != emptyTag) begin
      if (cur.q == alu_tag) begin
        res.v = alu_data;
        res.q = emptyTag;
      end else if (cur.q == lsb_tag) begin
        res.v = lsb_data;
        res.q = emptyTag;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_pick.sv
// rtl/rs_pick.sv - lowest-index priority encoder
//
// Purpose: returns the index of the lowest set bit of vec.
// Ports:
//   vec   in  WIDTH  request vector
//   idx   out IW     index of lowest set bit (0 when none)
//   valid out 1      at least one bit set
module rs_pick #(
  parameter int WIDTH = 16,
  parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// rtl/rs_alu.sv - ALU reservation station with CDB wakeup and in-order-index issue
//
// Purpose: buffers dispatched ALU/branch ops, snoops the ALU and LSB result
// buses for operands, and issues the lowest-index ready entry each cycle into
// registered ex-stage inputs.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (0 = freeze), rob_clear (flush)
//   disp_en/op/vj/vk/qj/qk/imm/pc/tag   dispatch from decoder
//   rs_full                             all entries busy
//   alu_cdb_tag/data, lsb_cdb_tag/data  result buses
//   op_type_ex, data_rs1_ex, data_rs2_ex, imm_ex, pc_ex, tag_in_rob  issue outputs
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEFAULT
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   rob_clear,
  input  logic                   disp_en,
  input  logic [opTypeWidth-1:0] disp_op,
  input  logic [dataWidth-1:0]   disp_vj,
  input  logic [dataWidth-1:0]   disp_vk,
  input  logic [tagWidth-1:0]    disp_qj,
  input  logic [tagWidth-1:0]    disp_qk,
  input  logic [immWidth-1:0]    disp_imm,
  input  logic [addrWidth-1:0]   disp_pc,
  input  logic [tagWidth-1:0]    disp_tag,
  output logic                   rs_full,
  input  logic [tagWidth-1:0]    alu_cdb_tag,
  input  logic [dataWidth-1:0]   alu_cdb_data,
  input  logic [tagWidth-1:0]    lsb_cdb_tag,
  input  logic [dataWidth-1:0]   lsb_cdb_data,
  output logic [opTypeWidth-1:0] op_type_ex,
  output logic [dataWidth-1:0]   data_rs1_ex,
  output logic [dataWidth-1:0]   data_rs2_ex,
  output logic [immWidth-1:0]    imm_ex,
  output logic [addrWidth-1:0]   pc_ex,
  output logic [tagWidth-1:0]    tag_in_rob
);

  localparam int IW = $clog2(RS_DEPTH);

  rs_entry_t           ent [RS_DEPTH];
  operand_t            woke_j [RS_DEPTH];
  operand_t            woke_k [RS_DEPTH];
  logic [RS_DEPTH-1:0] busy;
  logic [RS_DEPTH-1:0] free_vec;
  logic [RS_DEPTH-1:0] ready_vec;
  logic [IW-1:0]       free_idx;
  logic [IW-1:0]       iss_idx;
  logic                free_valid;
  logic                iss_valid;
  rs_entry_t           disp_entry;
  operand_t            disp_j;
  operand_t            disp_k;
  logic                advance;

  // Entry state only moves when not frozen and not being flushed.
  assign advance  = rdy_in && !rob_clear;
  assign free_vec = ~busy;
  assign rs_full  = &busy;

  // Readiness uses registered q fields only, so a wakeup this cycle
  // becomes issuable one cycle later.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready_vec[i] = busy[i] && (ent[i].qj == emptyTag) && (ent[i].qk == emptyTag);
      woke_j[i]    = snoop('{v: ent[i].vj, q: ent[i].qj},
                           alu_cdb_tag, alu_cdb_data, lsb_cdb_tag, lsb_cdb_data);
      woke_k[i]    = snoop('{v: ent[i].vk, q: ent[i].qk},
                           alu_cdb_tag, alu_cdb_data, lsb_cdb_tag, lsb_cdb_data);
    end
  end

  always_comb begin
    disp_j          = snoop('{v: disp_vj, q: disp_qj},
                            alu_cdb_tag, alu_cdb_data, lsb_cdb_tag, lsb_cdb_data);
    disp_k          = snoop('{v: disp_vk, q: disp_qk},
                            alu_cdb_tag, alu_cdb_data, lsb_cdb_tag, lsb_cdb_data);
    disp_entry.op   = disp_op;
    disp_entry.vj   = disp_j.v;
    disp_entry.qj   = disp_j.q;
    disp_entry.vk   = disp_k.v;
    disp_entry.qk   = disp_k.q;
    disp_entry.imm  = disp_imm;
    disp_entry.pc   = disp_pc;
    disp_entry.dest = disp_tag;
  end

  rs_pick #(.WIDTH(RS_DEPTH)) u_free_pick (
    .vec   (free_vec),
    .idx   (free_idx),
    .valid (free_valid)
  );

  rs_pick #(.WIDTH(RS_DEPTH)) u_ready_pick (
    .vec   (ready_vec),
    .idx   (iss_idx),
    .valid (iss_valid)
  );

  // Busy vector and issue registers. The free slot is never busy and the
  // issued slot always is, so set and clear never collide.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy        <= '0;
      op_type_ex  <= emptyOp;
      data_rs1_ex <= emptyData;
      data_rs2_ex <= emptyData;
      imm_ex      <= '0;
      pc_ex       <= '0;
      tag_in_rob  <= emptyTag;
    end else if (rob_clear) begin
      busy       <= '0;
      op_type_ex <= emptyOp;
      tag_in_rob <= emptyTag;
    end else if (!rdy_in) begin
      op_type_ex <= emptyOp;
    end else begin
      if (iss_valid) begin
        op_type_ex    <= ent[iss_idx].op;
        data_rs1_ex   <= ent[iss_idx].vj;
        data_rs2_ex   <= ent[iss_idx].vk;
        imm_ex        <= ent[iss_idx].imm;
        pc_ex         <= ent[iss_idx].pc;
        tag_in_rob    <= ent[iss_idx].dest;
        busy[iss_idx] <= 1'b0;
      end else begin
        op_type_ex <= emptyOp;
      end
      if (disp_en && free_valid) begin
        busy[free_idx] <= 1'b1;
      end
    end
  end

  // Entry payload needs no reset: busy qualifies every use of it.
  always_ff @(posedge clk_in) begin
    if (advance && !rst_in) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy[i]) begin
          ent[i].vj <= woke_j[i].v;
          ent[i].qj <= woke_j[i].q;
          ent[i].vk <= woke_k[i].v;
          ent[i].qk <= woke_k[i].q;
        end
      end
      if (disp_en && free_valid) begin
        ent[free_idx] <= disp_entry;
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// tb/tb_rs_alu.sv - self-checking bench for rs_alu
module tb_rs_alu;
  import rs_alu_pkg::*;

  localparam int DEPTH = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   rdy_in;
  logic                   rob_clear;
  logic                   disp_en;
  logic [opTypeWidth-1:0] disp_op;
  logic [dataWidth-1:0]   disp_vj, disp_vk;
  logic [tagWidth-1:0]    disp_qj, disp_qk, disp_tag;
  logic [immWidth-1:0]    disp_imm;
  logic [addrWidth-1:0]   disp_pc;
  logic                   rs_full;
  logic [tagWidth-1:0]    alu_cdb_tag, lsb_cdb_tag;
  logic [dataWidth-1:0]   alu_cdb_data, lsb_cdb_data;
  logic [opTypeWidth-1:0] op_type_ex;
  logic [dataWidth-1:0]   data_rs1_ex, data_rs2_ex;
  logic [immWidth-1:0]    imm_ex;
  logic [addrWidth-1:0]   pc_ex;
  logic [tagWidth-1:0]    tag_in_rob;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rs_alu #(.RS_DEPTH(DEPTH)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .rdy_in       (rdy_in),
    .rob_clear    (rob_clear),
    .disp_en      (disp_en),
    .disp_op      (disp_op),
    .disp_vj      (disp_vj),
    .disp_vk      (disp_vk),
    .disp_qj      (disp_qj),
    .disp_qk      (disp_qk),
    .disp_imm     (disp_imm),
    .disp_pc      (disp_pc),
    .disp_tag     (disp_tag),
    .rs_full      (rs_full),
    .alu_cdb_tag  (alu_cdb_tag),
    .alu_cdb_data (alu_cdb_data),
    .lsb_cdb_tag  (lsb_cdb_tag),
    .lsb_cdb_data (lsb_cdb_data),
    .op_type_ex   (op_type_ex),
    .data_rs1_ex  (data_rs1_ex),
    .data_rs2_ex  (data_rs2_ex),
    .imm_ex       (imm_ex),
    .pc_ex        (pc_ex),
    .tag_in_rob   (tag_in_rob)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a bag of waiting ops, each with two operand slots
  // that are either a known value or a producer tag still outstanding.
  bit          m_used [DEPTH];
  int          m_op [DEPTH], m_vj [DEPTH], m_vk [DEPTH], m_qj [DEPTH], m_qk [DEPTH];
  int          m_imm [DEPTH], m_pc [DEPTH], m_dest [DEPTH];
  int          e_op, e_rs1, e_rs2, e_imm, e_pc, e_tag;
  bit          e_tag_chk, m_init;
  int          sel, fr, occ;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_used[i] = 0;
      e_op = 0; e_tag = 0; e_tag_chk = 1; m_init = 1;
    end else begin
      e_tag_chk = 0;
      if (rob_clear) begin
        for (int i = 0; i < DEPTH; i++) m_used[i] = 0;
        e_op = 0; e_tag = 0; e_tag_chk = 1;
      end else if (!rdy_in) begin
        e_op = 0;
      end else begin
        sel = -1; fr = -1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (m_used[i] && m_qj[i] == 0 && m_qk[i] == 0) sel = i;
          if (!m_used[i]) fr = i;
        end
        if (sel >= 0) begin
          e_op = m_op[sel]; e_rs1 = m_vj[sel]; e_rs2 = m_vk[sel];
          e_imm = m_imm[sel]; e_pc = m_pc[sel]; e_tag = m_dest[sel];
          e_tag_chk = 1; m_used[sel] = 0;
        end else e_op = 0;
        for (int i = 0; i < DEPTH; i++) begin
          if (m_used[i]) begin
            if (m_qj[i] != 0 && m_qj[i] == int'(alu_cdb_tag)) begin m_vj[i] = alu_cdb_data; m_qj[i] = 0; end
            else if (m_qj[i] != 0 && m_qj[i] == int'(lsb_cdb_tag)) begin m_vj[i] = lsb_cdb_data; m_qj[i] = 0; end
            if (m_qk[i] != 0 && m_qk[i] == int'(alu_cdb_tag)) begin m_vk[i] = alu_cdb_data; m_qk[i] = 0; end
            else if (m_qk[i] != 0 && m_qk[i] == int'(lsb_cdb_tag)) begin m_vk[i] = lsb_cdb_data; m_qk[i] = 0; end
          end
        end
        if (disp_en && fr >= 0) begin
          m_used[fr] = 1; m_op[fr] = disp_op; m_imm[fr] = disp_imm;
          m_pc[fr] = disp_pc; m_dest[fr] = disp_tag;
          m_vj[fr] = disp_vj; m_qj[fr] = disp_qj;
          m_vk[fr] = disp_vk; m_qk[fr] = disp_qk;
          if (m_qj[fr] != 0 && m_qj[fr] == int'(alu_cdb_tag)) begin m_vj[fr] = alu_cdb_data; m_qj[fr] = 0; end
          else if (m_qj[fr] != 0 && m_qj[fr] == int'(lsb_cdb_tag)) begin m_vj[fr] = lsb_cdb_data; m_qj[fr] = 0; end
          if (m_qk[fr] != 0 && m_qk[fr] == int'(alu_cdb_tag)) begin m_vk[fr] = alu_cdb_data; m_qk[fr] = 0; end
          else if (m_qk[fr] != 0 && m_qk[fr] == int'(lsb_cdb_tag)) begin m_vk[fr] = lsb_cdb_data; m_qk[fr] = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      if (rst) begin
        check("rst_op", 32'(op_type_ex), 0);
        check("rst_full", 32'(rs_full), 0);
        check("rst_tag", 32'(tag_in_rob), 0);
        check("rst_rs1", data_rs1_ex, 0);
        check("rst_rs2", data_rs2_ex, 0);
        check("rst_imm", imm_ex, 0);
        check("rst_pc", pc_ex, 0);
      end else begin
        occ = 0;
        for (int i = 0; i < DEPTH; i++) occ += int'(m_used[i]);
        check("model_full", 32'(rs_full), 32'(occ == DEPTH));
        check("model_op", 32'(op_type_ex), 32'(e_op));
        if (e_op != 0) begin
          check("model_rs1", data_rs1_ex, 32'(e_rs1));
          check("model_rs2", data_rs2_ex, 32'(e_rs2));
          check("model_imm", imm_ex, 32'(e_imm));
          check("model_pc", pc_ex, 32'(e_pc));
        end
        if (e_op != 0 || e_tag_chk) check("model_tag", 32'(tag_in_rob), 32'(e_tag));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    disp_en = 0; rob_clear = 0; rdy_in = 1;
    alu_cdb_tag = 0; alu_cdb_data = 0; lsb_cdb_tag = 0; lsb_cdb_data = 0;
  endtask

  task automatic disp(input int op, input int vj, input int vk, input int qj, input int qk,
                      input int imm, input int pc, input int tag);
    disp_en = 1; disp_op = opTypeWidth'(op); disp_vj = vj; disp_vk = vk;
    disp_qj = tagWidth'(qj); disp_qk = tagWidth'(qk); disp_imm = imm; disp_pc = pc;
    disp_tag = tagWidth'(tag);
  endtask

  initial begin
    m_init = 0;
    rst = 1;
    idle();
    disp(0, 0, 0, 0, 0, 0, 0, 0);
    disp_en = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_op", 32'(op_type_ex), 0);
    check("reset_full", 32'(rs_full), 0);
    @(posedge clk); #1;
    rst = 0;

    // ready dispatch: visible two cycles later, then gone
    disp(OP_ADD, 5, 7, 0, 0, 32'h20, 32'h100, 3);
    tick(); idle();
    @(negedge clk); check("add_t1_empty", 32'(op_type_ex), 0);
    tick();
    @(negedge clk);
    check("add_op", 32'(op_type_ex), 32'(OP_ADD));
    check("add_rs1", data_rs1_ex, 5);
    check("add_rs2", data_rs2_ex, 7);
    check("add_tag", 32'(tag_in_rob), 3);
    tick();
    @(negedge clk); check("add_t3_empty", 32'(op_type_ex), 0);

    // wakeup from ALU bus
    disp(OP_SUB, 0, 1, 4, 0, 0, 32'h104, 6);
    tick(); idle(); alu_cdb_tag = 4; alu_cdb_data = 32'h10;
    tick(); idle();
    @(negedge clk); check("sub_not_yet", 32'(op_type_ex), 0);
    tick();
    @(negedge clk);
    check("sub_op", 32'(op_type_ex), 32'(OP_SUB));
    check("sub_rs1", data_rs1_ex, 32'h10);
    check("sub_rs2", data_rs2_ex, 1);
    check("sub_tag", 32'(tag_in_rob), 6);

    // dispatch-cycle bypass from LSB bus
    tick();
    disp(OP_OR, 3, 0, 0, 9, 0, 32'h108, 7);
    lsb_cdb_tag = 9; lsb_cdb_data = 32'hABCD;
    tick(); idle();
    tick();
    @(negedge clk);
    check("byp_op", 32'(op_type_ex), 32'(OP_OR));
    check("byp_rs1", data_rs1_ex, 3);
    check("byp_rs2", data_rs2_ex, 32'hABCD);

    // fill all entries waiting on tag 2, then drain in index order
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      disp(OP_ADD, 0, i, 2, 0, i, 32'h200 + 4 * i, 10 + i);
      tick();
    end
    idle();
    @(negedge clk); check("full_set", 32'(rs_full), 1);
    tick(); alu_cdb_tag = 2; alu_cdb_data = 32'h55;
    tick(); idle();
    @(negedge clk);
    check("full_b1", 32'(rs_full), 1);
    check("full_b1_op", 32'(op_type_ex), 0);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      @(negedge clk);
      check("ord_op", 32'(op_type_ex), 32'(OP_ADD));
      check("ord_tag", 32'(tag_in_rob), 32'(10 + i));
      check("ord_rs1", data_rs1_ex, 32'h55);
      check("ord_rs2", data_rs2_ex, 32'(i));
      if (i == 0) check("full_cleared", 32'(rs_full), 0);
    end
    tick();
    @(negedge clk); check("drained", 32'(op_type_ex), 0);

    // flush with busy entries and a simultaneous dispatch
    for (int i = 0; i < 5; i++) begin
      disp(OP_XOR, 0, 0, 31, 0, 0, 32'h300, 20 + i);
      tick();
    end
    disp(OP_SUB, 1, 1, 0, 0, 0, 32'h320, 8);
    rob_clear = 1;
    tick(); idle();
    @(negedge clk);
    check("flush_op", 32'(op_type_ex), 0);
    check("flush_full", 32'(rs_full), 0);
    check("flush_tag", 32'(tag_in_rob), 0);
    disp(OP_ADD, 9, 1, 0, 0, 0, 32'h400, 12);
    tick(); idle();
    tick();
    @(negedge clk);
    check("post_flush_op", 32'(op_type_ex), 32'(OP_ADD));
    check("post_flush_tag", 32'(tag_in_rob), 12);
    tick();
    @(negedge clk); check("flushed_sub_gone", 32'(op_type_ex), 0);

    // asynchronous reset mid-run with three waiting entries
    for (int i = 0; i < 3; i++) begin
      disp(OP_OR, 0, 0, 30, 0, 0, 32'h500, 1 + i);
      tick();
    end
    disp(OP_ADD, 2, 3, 0, 0, 32'h44, 32'h510, 13);
    tick(); idle();
    tick(); #1;
    check("pre_rst_op", 32'(op_type_ex), 32'(OP_ADD));
    rst = 1;
    #1;
    check("async_rst_op", 32'(op_type_ex), 0);
    check("async_rst_tag", 32'(tag_in_rob), 0);
    check("async_rst_rs1", data_rs1_ex, 0);
    check("async_rst_full", 32'(rs_full), 0);
    @(posedge clk); #1;
    rst = 0;
    alu_cdb_tag = 30; alu_cdb_data = 1;
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("no_issue_after_rst", 32'(op_type_ex), 0);
      tick();
    end

    // freeze: ready entry held, dispatch ignored
    disp(OP_XOR, 1, 2, 0, 0, 0, 32'h600, 5);
    tick(); idle(); rdy_in = 0;
    disp(OP_ADD, 4, 4, 0, 0, 0, 32'h604, 14);
    @(negedge clk); check("frz1_op", 32'(op_type_ex), 0);
    tick();
    @(negedge clk); check("frz2_op", 32'(op_type_ex), 0);
    tick(); idle();
    @(negedge clk); check("thaw_op", 32'(op_type_ex), 0);
    tick();
    @(negedge clk);
    check("frz_issue_op", 32'(op_type_ex), 32'(OP_XOR));
    check("frz_issue_tag", 32'(tag_in_rob), 5);
    tick();
    @(negedge clk); check("frz_disp_ignored", 32'(op_type_ex), 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_alu.md
# rs_alu

Reservation station and issue scheduler for the integer ALU (`ex`). It buffers dispatched ALU and branch micro-ops and tracks their operand readiness by snooping the ALU and load/store result buses. Each cycle it selects one ready entry and drives the ALU's registered input ports. It sits between the decoder/dispatch stage and `ex`; the ROB supplies destination tags and the flush signal.

## Interface
- RS_DEPTH, 16, number of station entries (power of 2, ≥2)
- clk_in  in  1  clock
- rst_in  in  1  reset; asynchronous, active-high
- rdy_in  in  1  global ready; low = freeze
- rob_clear  in  1  mispredict flush from the ROB
- disp_en  in  1  dispatch strobe; the decoder asserts it only when rs_full=0
- disp_op  in  opTypeWidth  op type
- disp_vj, disp_vk  in  dataWidth  operand values; vk carries shamt for SLLI/SRLI/SRAI
- disp_qj, disp_qk  in  tagWidth  producer tags; emptyTag means the value is valid
- disp_imm  in  immWidth  immediate
- disp_pc  in  addrWidth  instruction PC
- disp_tag  in  tagWidth  destination ROB tag
- rs_full  out  1  all entries busy
- alu_cdb_tag / alu_cdb_data  in  tagWidth / dataWidth  ALU writeback (combinational from `ex`)
- lsb_cdb_tag / lsb_cdb_data  in  tagWidth / dataWidth  LSB writeback
- op_type_ex  out  opTypeWidth  issued op; emptyOp = no issue
- data_rs1_ex, data_rs2_ex  out  dataWidth  issued operands
- imm_ex  out  immWidth  issued immediate
- pc_ex  out  addrWidth  issued PC
- tag_in_rob  out  tagWidth  issued destination tag

## Operation
- Entry fields: busy, op, vj, vk, qj, qk, imm, pc, dest.
- **Dispatch.** When disp_en=1, the lowest-index free entry is written.
  - Dispatch-cycle bypass: if disp_qj (or disp_qk) is not emptyTag and equals a CDB tag valid this cycle, capture that CDB's data and store the tag as emptyTag.
  - If both CDBs match, alu_cdb has priority.
- **Wakeup.** Each cycle, every busy entry whose qj or qk equals a non-empty CDB tag latches the data and clears that q to emptyTag.
- **Select.** Ready means busy && qj==emptyTag && qk==emptyTag. The lowest-index ready entry is issued: its fields are registered to the outputs and its busy bit is cleared at the same edge. If no entry is ready, op_type_ex=emptyOp.
- **Timing of readiness.** Readiness is evaluated on registered state only. An entry woken in cycle t issues no earlier than the edge ending cycle t+1.
- **Flush.** rob_clear=1 clears all busy bits and sets op_type_ex=emptyOp and tag_in_rob=emptyTag at the next edge. Dispatch and wakeup in that cycle are discarded.
- **Freeze.** rdy_in=0 freezes entry state and ignores disp_en. op_type_ex=emptyOp while frozen, so no writeback is duplicated.
- **Full flag.** rs_full is combinational from the registered busy vector. A slot freed by issue is reusable from the next cycle.
- **Simultaneous dispatch and issue.** Dispatch uses the free slot computed from pre-edge state, so the two never target the same entry.

## Timing
- Reset (asynchronous):
  - all busy=0, rs_full=0
  - op_type_ex=emptyOp, tag_in_rob=emptyTag
  - data_rs1_ex, data_rs2_ex, imm_ex, pc_ex = 0
- Latency:
  - A ready op dispatched in cycle t occupies an entry in t+1.
  - Its outputs are valid in t+2.
  - `ex` result on alu_cdb is valid in t+2.
- Throughput: one issue per cycle.
- Issued outputs are held for exactly one cycle. Next cycle they show the next issue or emptyOp.

## Structure
- Shared package/defines: opTypeWidth, dataWidth, immWidth, addrWidth, tagWidth, emptyTag, emptyOp, emptyData, RS_DEPTH default.
- Sub-module `rs_pick`: parameterised lowest-index priority encoder (vector in → index and valid out). It is instantiated twice, once for free-slot selection and once for ready selection.

## Test plan
- **Reset:** assert rst_in mid-run with 3 busy entries → outputs at reset values immediately; rs_full=0; no issue after release.
- **Ready dispatch:** ADD vj=5, vk=7, qj=qk=emptyTag, tag=3 at cycle 0 → cycle 2 shows op=ADD, rs1=5, rs2=7, tag_in_rob=3; cycle 3 shows op=emptyOp.
- **Wakeup:**
  - Dispatch SUB qj=4, vk=1, tag=6.
  - Next cycle, alu_cdb_tag=4, data=0x10.
  - → issue one cycle later with rs1=0x10, rs2=1, tag=6.
- **Bypass:** dispatch with qk=9 in the same cycle lsb_cdb_tag=9, data=0xABCD → entry ready; issues at t+2 with rs2=0xABCD.
- **Ordering and full:**
  - Fill 16 entries, all waiting on tag 2 → rs_full=1.
  - Broadcast tag 2 → entries issue in index order 0..15, one per cycle.
  - rs_full=0 the cycle after the first issue.
- **Flush:**
  - 5 busy entries plus a dispatch; rob_clear=1 → next cycle op_type_ex=emptyOp, rs_full=0.
  - A subsequent ready dispatch issues normally at t+2.
